sumador_serie: RTL and testbench
================================

Name: sumador_serie

Overview:
Bit-serial N-bit adder built around the existing 1-bit full adder, instantiated once.
- Accepts two N-bit operands and a carry-in on a start strobe.
- Adds one bit per clock, LSB first, holding the carry in a flip-flop.
- Presents the N-bit sum and carry-out with a one-cycle done pulse.
- Sits directly downstream of operand sources and drives sumador_1bit cycle by cycle.

Parameters:
- N, 8, operand/result width in bits; legal range N >= 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE or FIN.
- A  input  N  operand A; captured on the accepted start edge.
- B  input  N  operand B; captured on the accepted start edge.
- Ci  input  1  carry-in; captured on the accepted start edge.
- S  output  N  sum; registered, holds the last completed result.
- Co  output  1  carry-out; registered, holds the last completed result.
- busy  output  1  high while bits are being processed (SUMA).
- done  output  1  one-cycle pulse when S/Co have just been updated.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, S=0, Co=0, busy=0, done=0, shift registers=0, carry FF=0, bit counter=0.
- FSM has three states, encoded 2 bits:
  - IDLE: start=1 loads regA<=A, regB<=B, carry<=Ci, cnt<=0, then goes to SUMA. start=0 stays in IDLE.
  - SUMA: each edge, sumador_1bit takes A=regA[0], B=regB[0], Ci=carry. Its S bit shifts into the MSB of regS (shift right). regA and regB shift right by one. carry<=Co, cnt<=cnt+1.
    - On the edge where cnt==N-1: S<=final regS value including the current bit, Co<=the adder's Co, state->FIN.
  - FIN: done=1 for exactly this cycle.
    - start=1 loads new operands exactly as in IDLE and goes to SUMA.
    - Otherwise goes to IDLE.
- busy=1 exactly while state==SUMA. done=1 exactly while state==FIN. Both are decoded from registered state.
- Latency: with start accepted at edge E0, SUMA occupies edges E1..EN, and done is high in the cycle following EN. Throughput is one add per N+1 cycles.
- start during SUMA is ignored. Operands are not re-sampled and no error flag is raised.
- A, B and Ci may change freely after the accepting edge without affecting the result.
- S and Co change only at completion. They are stable during SUMA, showing the previous result.
- Arithmetic: {Co,S} = A + B + Ci, unsigned, N+1 bits, no truncation of the carry.
- N=1: a single SUMA cycle; done follows one edge after acceptance.
- Reset mid-operation: the operation is aborted, no done pulse, and outputs return to reset values immediately.
- Counter width is clog2(N) bits with a minimum of 1. It never exceeds N-1.

Optional Feature:
- Macro name: SUMADOR_SERIE_OVF_EN.
- Defined: adds output port V (1 bit), the signed two's-complement overflow.
  - V is registered at completion alongside S/Co as the XOR of the carry into and out of the MSB stage.
  - V resets to 0 and holds between operations.
- Not defined: no V port and no associated logic. Behaviour is otherwise identical.

Decomposition:
- Shared header sumador_serie_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_SUMA=2'd1, ST_FIN=2'd2;
  - the default width constant.
- One sub-module: the existing sumador_1bit (ports A, B, Ci, S, Co), instantiated once as the bit-slice. No other sub-modules.

Test Plan:
1. N=8, A=0x3C, B=0x05, Ci=0, start one cycle -> busy high 8 cycles, then done pulse with S=0x41, Co=0.
2. A=0xFF, B=0x01, Ci=0 -> S=0x00, Co=1. Then A=0xFF, B=0xFF, Ci=1 -> S=0xFF, Co=1.
3. start=1 again 3 cycles into SUMA with A=0x11, B=0x22 -> ignored. Result equals the first operands and exactly one done pulse.
4. rst asserted at cycle 4 of SUMA -> S=0, Co=0, busy=0, done=0 at once, and no done pulse afterwards. A new start after release completes correctly.
5. start held high in FIN with new operands A=0x10, B=0x20 -> next SUMA begins without an IDLE cycle and yields S=0x30, Co=0.
6. (SUMADOR_SERIE_OVF_EN) A=0x7F, B=0x01 -> S=0x80, Co=0, V=1. A=0x80, B=0x80 -> S=0x00, Co=1, V=1. A=0x05, B=0x03 -> V=0.

Source files
------------

// File: rtl/sumador_serie_pkg.sv
// -----------------------------------------------------------------------------
// sumador_serie_pkg
// Shared definitions for the bit-serial adder:
//   - SUMADOR_SERIE_N_DEFAULT : default operand/result width
//   - state_e                 : FSM state encoding (2 bits)
// -----------------------------------------------------------------------------
package sumador_serie_pkg;

  localparam int SUMADOR_SERIE_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUMA = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage : sumador_serie_pkg

// File: rtl/sumador_1bit.sv
// -----------------------------------------------------------------------------
// sumador_1bit
// Combinational 1-bit full adder used as the bit-slice of the serial adder.
// Ports:
//   A, B  : input  operand bits
//   Ci    : input  carry in
//   S     : output sum bit
//   Co    : output carry out
// -----------------------------------------------------------------------------
module sumador_1bit (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic S,
  output logic Co
);

  logic prop_s;

  assign prop_s = A ^ B;
  assign S      = prop_s ^ Ci;
  assign Co     = (A & B) | (Ci & prop_s);

endmodule : sumador_1bit

// File: rtl/sumador_serie.sv
// -----------------------------------------------------------------------------
// sumador_serie
// Bit-serial N-bit adder. Operands are captured on an accepted start strobe
// and added one bit per clock, LSB first, through a single sumador_1bit with
// the carry held in a flip-flop. {Co,S} = A + B + Ci, unsigned, N+1 bits.
//
// Ports:
//   clk   : input  system clock, rising edge
//   rst   : input  asynchronous active-high reset
//   start : input  request strobe, honoured only in IDLE or FIN
//   A, B  : input  N-bit operands, captured on the accepted start edge
//   Ci    : input  carry-in, captured on the accepted start edge
//   S     : output registered N-bit sum, holds the last completed result
//   Co    : output registered carry-out, holds the last completed result
//   V     : output registered signed overflow (only with SUMADOR_SERIE_OVF_EN)
//   busy  : output high while bits are being processed
//   done  : output one-cycle pulse when S/Co have just been updated
//
// Configuration macro:
//   SUMADOR_SERIE_OVF_EN : when defined, adds the V overflow output.
// -----------------------------------------------------------------------------
module sumador_serie
  import sumador_serie_pkg::*;
#(
  parameter int N = SUMADOR_SERIE_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Ci,
  output logic [N-1:0] S,
  output logic         Co,
`ifdef SUMADOR_SERIE_OVF_EN
  output logic         V,
`endif
  output logic         busy,
  output logic         done
);

  // Counter is at least one bit wide so N=1 still has a legal vector.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e         state_r;
  logic [N-1:0]   reg_a_r;
  logic [N-1:0]   reg_b_r;
  logic           carry_r;
  logic [CW-1:0]  cnt_r;

  logic           s_s;
  logic           co_s;
  logic [N-1:0]   s_next_s;

  // Single bit-slice: always fed from the LSBs of the operand shift registers.
  sumador_1bit u_slice (
    .A  (reg_a_r[0]),
    .B  (reg_b_r[0]),
    .Ci (carry_r),
    .S  (s_s),
    .Co (co_s)
  );

  // The partial sum only needs N-1 bits of storage: the current slice output
  // supplies the MSB, so s_next_s is the full result on the last SUMA edge.
  generate
    if (N == 1) begin : g_single
      assign s_next_s = s_s;
    end else begin : g_multi
      logic [N-2:0] part_r;

      // Shift collected sum bits right, newest bit entering at the top.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          part_r <= '0;
        end else if (state_r == ST_SUMA) begin
          part_r <= s_next_s[N-1:1];
        end else begin
          part_r <= part_r;
        end
      end

      assign s_next_s = {s_s, part_r};
    end
  endgenerate

  // Main FSM: operand capture, serial stepping and result registration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      reg_a_r <= '0;
      reg_b_r <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      S       <= '0;
      Co      <= 1'b0;
`ifdef SUMADOR_SERIE_OVF_EN
      V       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_FIN: begin
          if (start) begin
            reg_a_r <= A;
            reg_b_r <= B;
            carry_r <= Ci;
            cnt_r   <= '0;
            state_r <= ST_SUMA;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_SUMA: begin
          reg_a_r <= reg_a_r >> 1;
          reg_b_r <= reg_b_r >> 1;
          carry_r <= co_s;
          if (cnt_r == CNT_LAST) begin
            S       <= s_next_s;
            Co      <= co_s;
`ifdef SUMADOR_SERIE_OVF_EN
            // carry_r here is the carry into the MSB stage.
            V       <= carry_r ^ co_s;
`endif
            cnt_r   <= '0;
            state_r <= ST_FIN;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            state_r <= ST_SUMA;
          end
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Status flags decoded straight from the state register (glitch-free).
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      ST_SUMA: busy = 1'b1;
      ST_FIN:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

endmodule : sumador_serie

// File: tb/tb_sumador_serie.sv
// -----------------------------------------------------------------------------
// tb_sumador_serie
// Self-checking bench for sumador_serie (N=8). A cycle-level reference model
// derived from the arithmetic definition runs alongside the DUT and a compare
// process checks busy/done/S/Co every cycle; directed tests add hand-computed
// expectations on top.
// -----------------------------------------------------------------------------
module tb_sumador_serie;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Ci;
  logic [N-1:0] S;
  logic         Co;
`ifdef SUMADOR_SERIE_OVF_EN
  logic         V;
`endif
  logic         busy;
  logic         done;

  int tests_run    = 0;
  int tests_failed = 0;
  bit chk_en       = 1'b0;

  always #5 clk = ~clk;

  sumador_serie #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Ci    (Ci),
    .S     (S),
    .Co    (Co),
`ifdef SUMADOR_SERIE_OVF_EN
    .V     (V),
`endif
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Signed overflow from operand/result signs.
  function automatic logic ovf(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
    logic [N-1:0] s;
    s = a + b + {{(N-1){1'b0}}, ci};
    return (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
  endfunction

  // Reference model: phase 0 idle, 1 adding (m_left cycles remain), 2 result cycle.
  int           m_phase = 0;
  int           m_left  = 0;
  logic [N:0]   m_sum   = '0;
  logic         m_vp    = 1'b0;
  logic [N-1:0] m_s     = '0;
  logic         m_co    = 1'b0;
  logic         m_v     = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_s     <= '0;
      m_co    <= 1'b0;
      m_v     <= 1'b0;
    end else if (m_phase == 1) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_phase <= 2;
        m_s     <= m_sum[N-1:0];
        m_co    <= m_sum[N];
        m_v     <= m_vp;
      end
    end else if (start) begin
      m_phase <= 1;
      m_left  <= N;
      m_sum   <= {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Ci};
      m_vp    <= ovf(A, B, Ci);
    end else begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 32'(busy), 32'(m_phase == 1));
      check("cyc_done", 32'(done), 32'(m_phase == 2));
      check("cyc_S", 32'(S), 32'(m_s));
      check("cyc_Co", 32'(Co), 32'(m_co));
`ifdef SUMADOR_SERIE_OVF_EN
      check("cyc_V", 32'(V), 32'(m_v));
`endif
    end
  end

  // Called at the first negedge after the accepting edge.
  task automatic wait_done(input string nm, output int busy_cyc);
    bit seen;
    int k;
    seen = 1'b0;
    k = 0;
    busy_cyc = 0;
    while (!seen && k < N + 8) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cyc++;
        @(negedge clk);
        k++;
      end
    end
    check({nm, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic run_op(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic ci, input logic [N-1:0] es, input logic eco, input logic ev);
    int bc;
    @(negedge clk);
    A = a; B = b; Ci = ci; start = 1'b1;
    @(negedge clk);
    // Scramble inputs after acceptance; result must not change.
    start = 1'b0; A = ~a; B = 8'h5A; Ci = ~ci;
    wait_done(nm, bc);
    check({nm, "_busy_cycles"}, 32'(bc), 32'(N));
    check({nm, "_S"}, 32'(S), 32'(es));
    check({nm, "_Co"}, 32'(Co), 32'(eco));
`ifdef SUMADOR_SERIE_OVF_EN
    check({nm, "_V"}, 32'(V), 32'(ev));
`else
    if (ev !== 1'b0 && ev !== 1'b1) check({nm, "_ev_known"}, 32'(ev), 32'd0);
`endif
  endtask

  initial begin
    int dcnt;
    int bc;
    logic [N-1:0] s_at;
    logic co_at;

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Ci = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_S", 32'(S), 32'h0);
    check("rst_Co", 32'(Co), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // 1: basic add
    run_op("t1", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
    // 2: carry out cases
    run_op("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // 3: start during SUMA is ignored
    @(negedge clk);
    A = 8'h12; B = 8'h34; Ci = 1'b0; start = 1'b1;
    dcnt = 0; s_at = '0; co_at = 1'b0;
    for (int i = 1; i <= 2 * N + 2; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 3) begin start = 1'b1; A = 8'h11; B = 8'h22; end
      if (i == 4) start = 1'b0;
      if (done) begin dcnt++; s_at = S; co_at = Co; end
    end
    check("t3_done_pulses", 32'(dcnt), 32'd1);
    check("t3_S", 32'(s_at), 32'h46);
    check("t3_Co", 32'(co_at), 32'h0);

    // 4: reset mid-operation
    @(negedge clk);
    A = 8'h55; B = 8'h2A; Ci = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_S", 32'(S), 32'h0);
    check("t4_rst_Co", 32'(Co), 32'h0);
    check("t4_rst_busy", 32'(busy), 32'h0);
    check("t4_rst_done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("t4_no_done", 32'(dcnt), 32'd0);
    run_op("t4_after", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

    // 5: back-to-back start from FIN
    @(negedge clk);
    A = 8'h01; B = 8'h02; Ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t5a", bc);
    check("t5a_S", 32'(S), 32'h03);
    A = 8'h10; B = 8'h20; Ci = 1'b0; start = 1'b1;
    @(negedge clk);
    check("t5_no_idle", 32'(busy), 32'h1);
    start = 1'b0; A = 8'hEE; B = 8'hEE;
    wait_done("t5b", bc);
    check("t5b_S", 32'(S), 32'h30);
    check("t5b_Co", 32'(Co), 32'h0);

`ifdef SUMADOR_SERIE_OVF_EN
    // 6: signed overflow
    run_op("t6a", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("t6b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("t6c", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_sumador_serie
